// File: rtl/phase_rotate_sched.sv
// phase_rotate_sched: round-robin scheduler sharing one 3-bit left-rotate stage, with an 8-phase sweep mode
module phase_3b #(
  parameter int W = 64
) (
  input  logic [W-1:0] din,
  input  logic [2:0]   k,
  output logic [W-1:0] dout
);
  logic [W-1:0] s1, s2;
  assign s1   = k[0] ? {din[W-2:0], din[W-1]}    : din;
  assign s2   = k[1] ? {s1[W-3:0], s1[W-1:W-2]}  : s1;
  assign dout = k[2] ? {s2[W-5:0], s2[W-1:W-4]}  : s2;
endmodule

module phase_rotate_sched #(
  parameter int BITSTREAM = 64,
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   base_load,
  input  logic [BITSTREAM-1:0]   base_bits,
  output logic                   base_ready,
  input  logic                   sweep_start,
  output logic                   sweep_done,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [3*NUM_REQ-1:0]   req_k,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BITSTREAM-1:0]   out_bits,
  output logic [ID_W-1:0]        out_id,
  output logic [2:0]             out_k,
  output logic                   out_sweep
);
  typedef enum logic [1:0] {EMPTY, ARB, SWEEP} state_t;
  state_t               state;
  logic [BITSTREAM-1:0] base, rot;
  logic [ID_W-1:0]      rr_ptr, g, idx, g_next;
  logic [2:0]           sweep_cnt, k_sel;
  logic [2:0]           k_arr [NUM_REQ];
  logic                 any, grant, slot_free;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_k
    assign k_arr[i] = req_k[3*i +: 3];
  end

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    any = 1'b0;
    g   = rr_ptr;
    idx = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req_valid[idx]) begin
        any = 1'b1;
        g   = idx;
      end
      idx = (idx == ID_W'(NUM_REQ-1)) ? '0 : idx + 1'b1;
    end
  end

  assign slot_free  = !out_valid | out_ready;
  assign grant      = state == ARB && !base_load && !sweep_start && slot_free && any;
  assign req_ready  = grant ? NUM_REQ'(1) << g : '0;
  assign base_ready = state != SWEEP;
  assign g_next     = (g == ID_W'(NUM_REQ-1)) ? '0 : g + 1'b1;
  assign k_sel      = state == SWEEP ? sweep_cnt : k_arr[g];

  phase_3b #(.W(BITSTREAM)) u_rot (.din(base), .k(k_sel), .dout(rot));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      base       <= '0;
      rr_ptr     <= '0;
      sweep_cnt  <= '0;
      out_valid  <= 1'b0;
      out_bits   <= '0;
      out_id     <= '0;
      out_k      <= '0;
      out_sweep  <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      if (slot_free) out_valid <= 1'b0;
      case (state)
        EMPTY: if (base_load) begin
          base  <= base_bits;
          state <= ARB;
        end
        ARB: if (base_load) begin
          base <= base_bits;
        end else if (sweep_start) begin
          sweep_cnt <= '0;
          state     <= SWEEP;
        end else if (grant) begin
          out_valid <= 1'b1;
          out_bits  <= rot;
          out_id    <= g;
          out_k     <= k_sel;
          out_sweep <= 1'b0;
          rr_ptr    <= g_next;
        end
        SWEEP: if (slot_free) begin
          out_valid <= 1'b1;
          out_bits  <= rot;
          out_id    <= '0;
          out_k     <= sweep_cnt;
          out_sweep <= 1'b1;
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == 3'd7) begin
            sweep_done <= 1'b1;
            state      <= ARB;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_phase_rotate_sched.sv
// tb_phase_rotate_sched: table vectors, directed corner sequences and random traffic against a behavioural model
module tb_phase_rotate_sched;
  localparam int W = 64;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst, base_load, sweep_start, out_ready;
  logic [W-1:0]  base_bits;
  logic [N-1:0]  req_valid;
  logic [3*N-1:0] req_k;
  logic          base_ready, sweep_done, out_valid, out_sweep;
  logic [N-1:0]  req_ready;
  logic [W-1:0]  out_bits;
  logic [1:0]    out_id;
  logic [2:0]    out_k;

  phase_rotate_sched #(.BITSTREAM(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .base_load(base_load), .base_bits(base_bits),
    .base_ready(base_ready), .sweep_start(sweep_start), .sweep_done(sweep_done),
    .req_valid(req_valid), .req_k(req_k), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .out_id(out_id), .out_k(out_k), .out_sweep(out_sweep)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // behavioural model: 0=empty, 1=arbitrate, 2=sweep
  int          m_st, m_ptr, m_cnt, m_gnt;
  logic [63:0] m_base, m_bits;
  logic        m_ov, m_sw, m_done;
  int          m_id, m_k;

  function automatic logic [63:0] rotl(input logic [63:0] b, input int k);
    return (b << k) | (b >> (64 - k));
  endfunction

  task automatic model_reset();
    m_st = 0; m_ptr = 0; m_cnt = 0; m_base = 0; m_bits = 0;
    m_ov = 0; m_sw = 0; m_done = 0; m_id = 0; m_k = 0;
  endtask

  task automatic model_comb();
    m_gnt = -1;
    if (m_st == 1 && !base_load && !sweep_start && (!m_ov || out_ready))
      for (int o = 0; o < N; o++)
        if (m_gnt < 0 && req_valid[(m_ptr + o) % N]) m_gnt = (m_ptr + o) % N;
  endtask

  task automatic model_edge();
    logic sf;
    sf = !m_ov || out_ready;
    m_done = 0;
    if (sf) m_ov = 0;
    if (m_st == 0) begin
      if (base_load) begin m_base = base_bits; m_st = 1; end
    end else if (m_st == 1) begin
      if (base_load) m_base = base_bits;
      else if (sweep_start) begin m_cnt = 0; m_st = 2; end
      else if (m_gnt >= 0) begin
        m_k = int'(req_k[3*m_gnt +: 3]);
        m_ov = 1; m_bits = rotl(m_base, m_k); m_id = m_gnt; m_sw = 0;
        m_ptr = (m_gnt + 1) % N;
      end
    end else if (sf) begin
      m_ov = 1; m_bits = rotl(m_base, m_cnt); m_k = m_cnt; m_id = 0; m_sw = 1;
      if (m_cnt == 7) begin m_done = 1; m_st = 1; m_cnt = 0; end
      else m_cnt++;
    end
  endtask

  task automatic cyc();
    logic [N-1:0] er;
    #1;
    model_comb();
    er = (m_gnt >= 0) ? N'(1) << m_gnt : '0;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("base_ready", 64'(base_ready), 64'(m_st != 2));
    @(posedge clk);
    model_edge();
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("out_bits", out_bits, m_bits);
    chk("out_id", 64'(out_id), 64'(m_id));
    chk("out_k", 64'(out_k), 64'(m_k));
    chk("out_sweep", 64'(out_sweep), 64'(m_sw));
    chk("sweep_done", 64'(sweep_done), 64'(m_done));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_bits", out_bits, 64'd0);
    chk("rst_out_id", 64'(out_id), 64'd0);
    chk("rst_out_k", 64'(out_k), 64'd0);
    chk("rst_out_sweep", 64'(out_sweep), 64'd0);
    chk("rst_sweep_done", 64'(sweep_done), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_base_ready", 64'(base_ready), 64'd1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [63:0] base;
    logic [2:0]  k;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int ids1[5] = '{0, 1, 2, 3, 0};
    int ids2[4] = '{1, 3, 0, 1};
    logic [63:0] sw_exp[8] = '{64'h8000_0000_0000_0001, 64'h3, 64'h6, 64'hC,
                               64'h18, 64'h30, 64'h60, 64'hC0};
    tbl[0] = '{64'h1, 3'd1, 64'h2};
    tbl[1] = '{64'h1, 3'd5, 64'h20};
    tbl[2] = '{64'h8000_0000_0000_0000, 3'd7, 64'h40};
    tbl[3] = '{64'h8000_0000_0000_0001, 3'd0, 64'h8000_0000_0000_0001};
    tbl[4] = '{64'hF0, 3'd4, 64'hF00};
    tbl[5] = '{64'hA000_0000_0000_0005, 3'd3, 64'h2D};
    rst = 0; base_load = 0; base_bits = 0; sweep_start = 0;
    req_valid = 0; req_k = 0; out_ready = 1;
    #2;
    do_reset();

    // requests before any base is loaded are ignored
    req_valid = 4'b0001;
    repeat (3) cyc();
    chk("empty_no_grant", 64'(out_valid), 64'd0);

    foreach (tbl[i]) begin
      base_load = 1; base_bits = tbl[i].base; req_valid = 0;
      cyc();
      base_load = 0; req_valid = 4'b0001; req_k = {9'd0, tbl[i].k};
      cyc();
      chk("tbl_valid", 64'(out_valid), 64'd1);
      chk("tbl_bits", out_bits, tbl[i].exp);
      chk("tbl_id", 64'(out_id), 64'd0);
      chk("tbl_k", 64'(out_k), 64'(tbl[i].k));
      req_valid = 0;
      cyc();
    end

    // round-robin fairness from a fresh pointer
    do_reset();
    base_load = 1; base_bits = 64'h1;
    cyc();
    base_load = 0; req_valid = 4'hF; req_k = {3'd3, 3'd2, 3'd1, 3'd0};
    foreach (ids1[i]) begin cyc(); chk("rr_id", 64'(out_id), 64'(ids1[i])); end
    req_valid = 4'b1011;
    foreach (ids2[i]) begin cyc(); chk("rr_skip_id", 64'(out_id), 64'(ids2[i])); end

    // back-pressure holds the slot and blocks grants
    req_valid = 4'hF; out_ready = 0;
    repeat (5) begin
      cyc();
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_id", 64'(out_id), 64'd1);
      chk("stall_bits", out_bits, 64'h2);
    end
    out_ready = 1;
    cyc();
    chk("resume_id", 64'(out_id), 64'd2);
    req_valid = 0;

    // full sweep
    base_load = 1; base_bits = 64'h8000_0000_0000_0001;
    cyc();
    base_load = 0; sweep_start = 1;
    cyc();
    sweep_start = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("sweep_bits", out_bits, sw_exp[i]);
      chk("sweep_k", 64'(out_k), 64'(i));
      chk("sweep_flag", 64'(out_sweep), 64'd1);
      chk("sweep_done_pulse", 64'(sweep_done), 64'(i == 7));
    end
    cyc();
    chk("sweep_done_clear", 64'(sweep_done), 64'd0);

    // base_load wins over a coincident request
    base_load = 1; base_bits = 64'h1234; req_valid = 4'b0001; req_k = 12'd1;
    #1;
    chk("bl_no_grant", 64'(req_ready), 64'd0);
    cyc();
    base_load = 0;
    cyc();
    chk("bl_new_base", out_bits, 64'h2468);
    req_valid = 0;

    // reset in the middle of a sweep
    sweep_start = 1;
    cyc();
    sweep_start = 0;
    repeat (3) cyc();
    #2;
    do_reset();
    req_valid = 4'b0001;
    repeat (8) begin cyc(); chk("post_rst_no_done", 64'(sweep_done), 64'd0); end

    // randomized traffic
    base_load = 1; base_bits = {$urandom, $urandom};
    cyc();
    for (int i = 0; i < 400; i++) begin
      base_load   = ($urandom_range(0, 15) == 0);
      base_bits   = {$urandom, $urandom};
      sweep_start = ($urandom_range(0, 31) == 0);
      req_valid   = N'($urandom);
      req_k       = (3*N)'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/phase_rotate_sched.md
Name: phase_rotate_sched

Overview:
- Scheduler sharing one PHASE_3b 3-bit left-rotate stage between NUM_REQ requesters. Each requester needs a rotated copy of a common base bitstream.
- Holds the base bitstream and arbitrates per-requester rotation requests round-robin.
- Also runs a sweep mode that emits all 8 rotations back-to-back.
- Output is a single registered slot with a valid/ready handshake. The block sits between the bitstream source and the downstream phase-consuming lanes.

Parameters:
- BITSTREAM, 64, bitstream width; must be >= 8.
- NUM_REQ, 4, number of requesters; must be >= 2.
- ID_W, $clog2(NUM_REQ), width of the requester index.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- base_load, input, 1, capture base_bits this cycle when base_ready=1.
- base_bits, input, BITSTREAM, new base bitstream.
- base_ready, output, 1, 1 when state != SWEEP.
- sweep_start, input, 1, start sweep; honoured only in ARB.
- sweep_done, output, 1, one-cycle pulse when the 8th sweep word is loaded into the output slot.
- req_valid, input, NUM_REQ, per-requester request.
- req_k, input, 3*NUM_REQ, rotate amount; requester i uses bits [3i+2:3i].
- req_ready, output, NUM_REQ, one-hot grant; transfer when req_valid[i] & req_ready[i].
- out_valid, output, 1, output slot full.
- out_ready, input, 1, downstream accept.
- out_bits, output, BITSTREAM, rotated bitstream.
- out_id, output, ID_W, granted requester index; 0 during sweep.
- out_k, output, 3, rotate amount applied.
- out_sweep, output, 1, word belongs to a sweep.

Behaviour:
- Reset (async, immediate):
  - state=EMPTY; base register=0; rr_ptr=0; sweep_cnt=0.
  - out_valid=0, out_bits=0, out_id=0, out_k=0, out_sweep=0, sweep_done=0.
  - Reset during a sweep abandons the sweep; no partial sweep_done.
- Rotation: out_bits = base rotated left by k (bit BITSTREAM-1 wraps into bit 0), computed by the instantiated PHASE_3b. k=0 passes the base through unchanged.
- slot_free = !out_valid | out_ready. The output slot loads only when slot_free.
- When out_valid=1 and out_ready=0, all out_* outputs hold stable.
- If slot_free and nothing loads, out_valid clears to 0.
- FSM, state EMPTY:
  - req_ready=0; sweep_start ignored.
  - base_load captures the base; next state ARB.
- FSM, state ARB, evaluated in priority order:
  1. base_load: capture the base; no grant this cycle (req_ready=0).
  2. Else sweep_start: sweep_cnt=0; next state SWEEP; no grant this cycle.
  3. Else if slot_free and any req_valid: grant the first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
     - req_ready = one-hot of that index, combinational in the same cycle.
     - Next edge: out_valid=1, out_bits=rot(base, req_k[g]), out_id=g, out_k=req_k[g], out_sweep=0.
     - rr_ptr=(g+1) mod NUM_REQ.
  4. Otherwise req_ready=0 and rr_ptr is unchanged.
- FSM, state SWEEP:
  - req_ready=0; base_load and sweep_start ignored; base_ready=0.
  - Each slot_free cycle loads rot(base, sweep_cnt) with out_k=sweep_cnt, out_sweep=1, out_id=0, then increments sweep_cnt.
  - When the loaded word has sweep_cnt=7: sweep_done=1 on that edge, next state ARB, sweep_cnt wraps to 0.
- Latency: grant cycle N gives out_valid at edge N+1. Throughput is 1 word/cycle while out_ready stays 1.
- req_k is sampled only in the grant cycle. rr_ptr never advances without a grant.

Test Plan:
- Reset, then req_valid=4'b0001 before any base_load → req_ready stays 0 and out_valid stays 0.
- base_load 64'h1, requester 0 k=1, then k=5 → out_bits 64'h2 then 64'h20, out_id=0, one-cycle latency. Then base 64'h8000_0000_0000_0000 with k=7 → 64'h40.
- All 4 requesters valid, out_ready=1 → out_id sequence 0,1,2,3,0. Drop requester 2 → sequence skips 2.
- out_ready=0 with slot full → out_* held for 5 cycles and req_ready=0. Raise out_ready → next grant follows the round-robin order.
- Base 64'h8000_0000_0000_0001, sweep_start, out_ready=1 → 8 words k=0..7: 8000_0000_0000_0001, 3, 6, C, 18, 30, 60, C0, each with out_sweep=1. sweep_done pulses with the last word; base_ready=0 throughout the sweep.
- base_load coincident with req_valid → no grant that cycle; next grant uses the new base.
- Assert rst mid-sweep (after 3 words) → all outputs zero immediately, state EMPTY, no sweep_done.
